// File: rtl/sccb_pkg.sv
// Shared SCCB target definitions: bus address bytes and FSM state encoding.
// Imported by sccb_in_filt and sccb_slave_rx.
package sccb_pkg;

    localparam logic [7:0] SCCB_WR_ADDR = 8'h78;
    localparam logic [7:0] SCCB_RD_ADDR = 8'h79;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_REG_HI,
        ST_ACK_HI,
        ST_REG_LO,
        ST_ACK_LO,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MACK
    } sccb_state_t;

    function automatic logic [7:0] dev_byte(input logic [6:0] addr,
                                            input logic       rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/sccb_in_filt.sv
// One bus line: synchroniser, FILT_LEN-sample glitch filter, edge pulses.
// Lines idle high, so the filtered level resets to 1.
module sccb_in_filt
    import sccb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_q    <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // a new level must be seen on FILT_LEN consecutive samples
            if (w_s == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                r_cnt  <= '0;
                r_q    <= w_s;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign q_o    = r_q;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/sccb_slave_rx.sv
// SCCB/I2C register-write target; SCCB_SLV_READ_EN adds the read branch.
// Frames are {dev+W, reg_hi, reg_lo, data...}; one wr_en per data byte.
module sccb_slave_rx
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic        clk_25M,
    input  logic        rst_100,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    logic w_scl_f, w_scl_rise, w_scl_fall;
    logic w_sda_f, w_sda_rise, w_sda_fall;

    sccb_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk_25M),
        .rst_n  (rst_100),
        .d_i    (scl_i),
        .q_o    (w_scl_f),
        .rise_o (w_scl_rise),
        .fall_o (w_scl_fall)
    );

    sccb_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk_25M),
        .rst_n  (rst_100),
        .d_i    (sda_i),
        .q_o    (w_sda_f),
        .rise_o (w_sda_rise),
        .fall_o (w_sda_fall)
    );

    sccb_state_t r_state, w_state;
    logic [3:0]  r_bitcnt, w_bitcnt;
    logic [7:0]  r_shift, w_shift;
    logic [7:0]  r_reg_hi, w_reg_hi;
    logic [15:0] r_ptr, w_ptr;
    logic        r_sda_oe, w_sda_oe;
    logic        r_wr_en, w_wr_en;
    logic [15:0] r_wr_addr, w_wr_addr;
    logic [7:0]  r_wr_data, w_wr_data;
    logic        r_busy, w_busy;
    logic        w_full;

    assign w_full = (r_bitcnt == 4'd8);

`ifdef SCCB_SLV_READ_EN
    logic        r_rw, w_rw;
    logic        r_mack, w_mack;
    logic        r_rd_req, w_rd_req;
    logic [15:0] r_rd_addr, w_rd_addr;

    always_ff @(posedge clk_25M or negedge rst_100) begin
        if (!rst_100) begin
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rw      <= w_rw;
            r_mack    <= w_mack;
            r_rd_req  <= w_rd_req;
            r_rd_addr <= w_rd_addr;
        end
    end

    assign rd_req  = r_rd_req;
    assign rd_addr = r_rd_addr;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^rd_data;
    assign rd_req      = 1'b0;
    assign rd_addr     = '0;
`endif

    always_ff @(posedge clk_25M or negedge rst_100) begin
        if (!rst_100) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_reg_hi  <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bitcnt  <= w_bitcnt;
            r_shift   <= w_shift;
            r_reg_hi  <= w_reg_hi;
            r_ptr     <= w_ptr;
            r_sda_oe  <= w_sda_oe;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bitcnt  = r_bitcnt;
        w_shift   = r_shift;
        w_reg_hi  = r_reg_hi;
        w_ptr     = r_ptr;
        w_sda_oe  = r_sda_oe;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_busy    = r_busy;
`ifdef SCCB_SLV_READ_EN
        w_rw      = r_rw;
        w_mack    = r_mack;
        w_rd_req  = 1'b0;
        w_rd_addr = r_rd_addr;
`endif
        if (w_sda_fall && w_scl_f) begin
            w_state  = ST_DEV;
            w_bitcnt = '0;
            w_sda_oe = 1'b0;
            w_busy   = 1'b1;
        end else if (w_sda_rise && w_scl_f) begin
            w_state  = ST_IDLE;
            w_bitcnt = '0;
            w_sda_oe = 1'b0;
            w_busy   = 1'b0;
        end else begin
`ifdef SCCB_SLV_READ_EN
            // read data arrives one cycle after the request
            if (r_rd_req) begin
                w_shift  = rd_data;
                w_sda_oe = ~rd_data[7];
            end
`endif
            unique case (r_state)
                ST_DEV, ST_REG_HI, ST_REG_LO, ST_WDATA: begin
                    if (w_scl_rise && !w_full) begin
                        w_shift  = {r_shift[6:0], w_sda_f};
                        w_bitcnt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && w_full) begin
                        w_bitcnt = '0;
                        w_sda_oe = 1'b1;
                        if (r_state == ST_DEV) begin
                            if (r_shift == dev_byte(DEV_ADDR, 1'b0)) begin
                                w_state = ST_ACK_DEV;
`ifdef SCCB_SLV_READ_EN
                                w_rw    = 1'b0;
                            end else if (r_shift == dev_byte(DEV_ADDR, 1'b1)) begin
                                w_state = ST_ACK_DEV;
                                w_rw    = 1'b1;
`endif
                            end else begin
                                w_state  = ST_IDLE;
                                w_sda_oe = 1'b0;
                            end
                        end else if (r_state == ST_REG_HI) begin
                            w_reg_hi = r_shift;
                            w_state  = ST_ACK_HI;
                        end else if (r_state == ST_REG_LO) begin
                            w_ptr   = {r_reg_hi, r_shift};
                            w_state = ST_ACK_LO;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_addr = r_ptr;
                            w_wr_data = r_shift;
                            w_ptr     = r_ptr + 16'd1;
                            w_state   = ST_ACK_W;
                        end
                    end
                end
                ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_W: begin
                    if (w_scl_fall) begin
                        w_sda_oe = 1'b0;
                        w_bitcnt = '0;
                        if (r_state == ST_ACK_DEV) begin
                            w_state = ST_REG_HI;
`ifdef SCCB_SLV_READ_EN
                            if (r_rw) begin
                                w_state   = ST_RDATA;
                                w_rd_req  = 1'b1;
                                w_rd_addr = r_ptr;
                                w_ptr     = r_ptr + 16'd1;
                            end
`endif
                        end else if (r_state == ST_ACK_HI) begin
                            w_state = ST_REG_LO;
                        end else begin
                            w_state = ST_WDATA;
                        end
                    end
                end
`ifdef SCCB_SLV_READ_EN
                ST_RDATA: begin
                    if (w_scl_rise && !w_full) begin
                        w_bitcnt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall && w_full) begin
                        w_state  = ST_MACK;
                        w_sda_oe = 1'b0;
                        w_bitcnt = '0;
                    end else if (w_scl_fall && r_bitcnt != 4'd0) begin
                        w_shift  = {r_shift[6:0], 1'b0};
                        w_sda_oe = ~r_shift[6];
                    end
                end
                ST_MACK: begin
                    if (w_scl_rise) begin
                        w_mack = w_sda_f;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_state   = ST_RDATA;
                            w_rd_req  = 1'b1;
                            w_rd_addr = r_ptr;
                            w_ptr     = r_ptr + 16'd1;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule
